inv_loop_probe: RTL and testbench
=================================

Name: inv_loop_probe

Overview:
- Clocked stimulus/measurement block for the driving end of an inverting delay element (inverter or inverter chain under test).
- Toggles a stimulus output and counts clock cycles until the element's inverted response arrives back.
- Reports last/min/max loop delay over a programmable number of edges, with timeout and pre-check error flags.
- Used in mixed-signal benches to characterise gate delays in clock-cycle units.

Parameters:
- CNT_W, 16, width of delay counter and delay result outputs
- TIMEOUT, 1023, max cycles to wait for a response edge before aborting; must be < 2**CNT_W
- SETTLE, 4, idle cycles between a captured response and the next stimulus toggle; must be >= 1

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a measurement run; ignored while busy
- n_meas  input  8  number of edges to measure; sampled when start is accepted
- resp  input  1  response from the element under test; asynchronous to clk
- stim  output  1  stimulus to the element under test
- busy  output  1  high from start acceptance through the DONE cycle
- done  output  1  one-cycle pulse at the end of a run
- timeout_err  output  1  set when a response edge is not seen within TIMEOUT; cleared on the next accepted start
- precheck_err  output  1  set when resp is not the inverse of stim at start; cleared on the next accepted start
- meas_count  output  8  edges successfully measured in the current/last run
- last_delay  output  CNT_W  most recent captured delay, in cycles
- min_delay  output  CNT_W  minimum delay this run
- max_delay  output  CNT_W  maximum delay this run

Behaviour:
- Reset (async, rst_n=0) values:
  - stim=0, busy=0, done=0, both error flags=0, meas_count=0, last_delay=0, min_delay=all ones, max_delay=0.
  - State=IDLE, synchroniser flops=0.
  - Reset mid-run aborts immediately; no done pulse is generated.
- resp passes through a 2-flop synchroniser (resp_s). The expected value is always ~stim.
- States: IDLE, LAUNCH, WAIT_RESP, SETTLE, DONE.
- IDLE:
  - On start, latch n_meas, clear both error flags and meas_count, set min_delay=all ones, max_delay=0, busy=1.
  - If n_meas==0 -> DONE (no toggle).
  - Else if resp_s != ~stim -> set precheck_err -> DONE.
  - Else -> LAUNCH.
- LAUNCH (1 cycle): stim <= ~stim; cnt <= 1 -> WAIT_RESP.
- WAIT_RESP, evaluated each cycle:
  - If resp_s == ~stim: last_delay <= cnt; min/max update (unsigned compare, captured value included); meas_count++ -> SETTLE.
  - Else if cnt == TIMEOUT: set timeout_err -> DONE.
  - Else cnt++.
  - Response check has priority over timeout in the same cycle.
- SETTLE: wait SETTLE cycles. Then, if meas_count == latched n_meas -> DONE, else -> LAUNCH.
- DONE (1 cycle): done=1. busy drops on the following cycle -> IDLE.
- Latency reference: a zero-delay combinational loop (resp = ~stim) yields last_delay = 3 (toggle edge + 2 sync flops). Element delay ≈ (last_delay − 3) cycles, ±1 cycle quantisation.
- start while busy: ignored, no state change.
- stim keeps its last value between runs; the next run toggles from that value.
- Result outputs hold their values until the next accepted start.

Decomposition:
- Shared package inv_probe_pkg: state enum type (IDLE, LAUNCH, WAIT_RESP, SETTLE, DONE); ZERO_DELAY_OFFSET = 3 constant.
- One sub-module, sync2: 2-flop synchroniser with async active-low reset to 0; reused by other probe blocks.

Test Plan:
- Zero-delay loop (resp = ~stim), n_meas=4, start -> four toggles of stim; last/min/max_delay = 3; meas_count=4; one done pulse; no errors.
- Loop through a 10-cycle registered delay line (inverting), n_meas=2 -> last/min/max = 13; stim alternates 0->1->0; run lasts exactly 2*(1+13+SETTLE)+2 cycles from start to done.
- Inverting delay line alternating 5 and 9 cycles per edge, n_meas=3 -> min_delay=8, max_delay=12, last_delay=8.
- resp tied 0, TIMEOUT=20, n_meas=5 -> timeout_err=1 after cnt reaches 20; meas_count=0; done pulses; next start clears timeout_err.
- resp tied 1 with stim=1 (not inverted), start -> precheck_err=1, done within 2 cycles, stim unchanged; n_meas=0 start -> done, meas_count=0, no toggle.
- rst_n pulsed low mid-WAIT_RESP -> immediately stim=0, busy=0, min=all ones, no done; start pulsed during busy -> run unaffected.

Source files
------------

// File: rtl/inv_probe_pkg.sv
// Shared types and constants for the inverting-loop probe family.
// State encoding plus the fixed latency of a zero-delay loop.
package inv_probe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_RESP,
    ST_SETTLE,
    ST_DONE
  } probe_state_e;

  // Toggle edge plus two synchroniser flops: a direct inverter reads back as 3.
  localparam int ZERO_DELAY_OFFSET = 3;

endpackage

// File: rtl/inv_loop_probe_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, reset to 0.
// Shared by the probe blocks that sample signals from an element under test.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/inv_loop_probe.sv
// Drives an inverting element, counts cycles until its inverted response returns,
// and reports last/min/max loop delay over a programmable number of edges.
module inv_loop_probe
  import inv_probe_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023,
  parameter int SETTLE  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       n_meas,
  input  logic             resp,
  output logic             stim,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  output logic             precheck_err,
  output logic [7:0]       meas_count,
  output logic [CNT_W-1:0] last_delay,
  output logic [CNT_W-1:0] min_delay,
  output logic [CNT_W-1:0] max_delay
);

  localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] TMO_LIMIT  = CNT_W'(TIMEOUT);
  localparam logic [SET_W-1:0] SET_RELOAD = SET_W'(SETTLE - 1);

  probe_state_e     state_q, state_d;
  logic             stim_q, stim_d;
  logic [7:0]       n_q, n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SET_W-1:0] set_q, set_d;
  logic             tmo_q, tmo_d;
  logic             pre_q, pre_d;
  logic [7:0]       meas_q, meas_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  logic resp_s;
  logic resp_ok;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (resp),
    .q_o   (resp_s)
  );

  // The element is inverting, so a settled loop always reads back ~stim.
  assign resp_ok = (resp_s == ~stim_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (n_meas == 8'd0) begin
            state_d = ST_DONE;
          end else if (!resp_ok) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        if (resp_ok) begin
          state_d = ST_SETTLE;
        end else if (cnt_q == TMO_LIMIT) begin
          state_d = ST_DONE;
        end
      end
      ST_SETTLE: begin
        if (set_q == '0) begin
          state_d = (meas_q == n_q) ? ST_DONE : ST_LAUNCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    stim_d = stim_q;
    n_d    = n_q;
    cnt_d  = cnt_q;
    set_d  = set_q;
    tmo_d  = tmo_q;
    pre_d  = pre_q;
    meas_d = meas_q;
    last_d = last_q;
    min_d  = min_q;
    max_d  = max_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          n_d    = n_meas;
          tmo_d  = 1'b0;
          pre_d  = 1'b0;
          meas_d = 8'd0;
          min_d  = '1;
          max_d  = '0;
          if ((n_meas != 8'd0) && !resp_ok) begin
            pre_d = 1'b1;
          end
        end
      end
      ST_LAUNCH: begin
        stim_d = ~stim_q;
        cnt_d  = CNT_W'(1);
      end
      ST_WAIT_RESP: begin
        // A response arriving on the timeout cycle still counts as a measurement.
        if (resp_ok) begin
          last_d = cnt_q;
          if (cnt_q < min_q) begin
            min_d = cnt_q;
          end
          if (cnt_q > max_q) begin
            max_d = cnt_q;
          end
          meas_d = meas_q + 8'd1;
          set_d  = SET_RELOAD;
        end else if (cnt_q == TMO_LIMIT) begin
          tmo_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SETTLE: begin
        if (set_q != '0) begin
          set_d = set_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q <= 1'b0;
      n_q    <= 8'd0;
      cnt_q  <= '0;
      set_q  <= '0;
      tmo_q  <= 1'b0;
      pre_q  <= 1'b0;
      meas_q <= 8'd0;
      last_q <= '0;
      min_q  <= '1;
      max_q  <= '0;
    end else begin
      stim_q <= stim_d;
      n_q    <= n_d;
      cnt_q  <= cnt_d;
      set_q  <= set_d;
      tmo_q  <= tmo_d;
      pre_q  <= pre_d;
      meas_q <= meas_d;
      last_q <= last_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    done         = (state_q == ST_DONE);
    stim         = stim_q;
    timeout_err  = tmo_q;
    precheck_err = pre_q;
    meas_count   = meas_q;
    last_delay   = last_q;
    min_delay    = min_q;
    max_delay    = max_q;
  end

endmodule

// File: tb/tb_inv_loop_probe.sv
// Bench for inv_loop_probe: a behavioural inverting element with per-edge delays
// drives resp, and each run is compared with delays predicted from the edge list.
module tb_inv_loop_probe;
  import inv_probe_pkg::*;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 20;
  localparam int SETTLE  = 4;
  localparam logic [CNT_W-1:0] ALL_ONES = '1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [7:0]       n_meas = 8'd0;
  logic             resp = 1'b1;
  logic             stim;
  logic             busy;
  logic             done;
  logic             timeout_err;
  logic             precheck_err;
  logic [7:0]       meas_count;
  logic [CNT_W-1:0] last_delay;
  logic [CNT_W-1:0] min_delay;
  logic [CNT_W-1:0] max_delay;

  int vectors = 0;
  int miscompares = 0;
  logic exp_stim = 1'b0;
  int   exp_last = 0;

  inv_loop_probe #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .n_meas       (n_meas),
    .resp         (resp),
    .stim         (stim),
    .busy         (busy),
    .done         (done),
    .timeout_err  (timeout_err),
    .precheck_err (precheck_err),
    .meas_count   (meas_count),
    .last_delay   (last_delay),
    .min_delay    (min_delay),
    .max_delay    (max_delay)
  );

  always #5 clk = ~clk;

  // Element model: each stim edge returns inverted after the next queued delay
  // (in cycles, 0 = combinational); tied mode holds resp at a fixed level.
  bit   tied = 1'b0;
  logic tied_val = 1'b0;
  logic prev_stim = 1'b0;
  bit   pending = 1'b0;
  int   rem = 0;
  logic target = 1'b0;
  int   dq[$];

  always @(negedge clk) begin
    if (tied) begin
      resp = tied_val;
      pending = 1'b0;
      prev_stim = stim;
    end else if (stim !== prev_stim) begin
      prev_stim = stim;
      target = ~stim;
      rem = (dq.size() > 0) ? dq.pop_front() : 0;
      if (rem == 0) begin
        resp = target;
        pending = 1'b0;
      end else begin
        pending = 1'b1;
      end
    end else if (pending) begin
      rem--;
      if (rem == 0) begin
        resp = target;
        pending = 1'b0;
      end
    end else begin
      resp = ~stim;
    end
  end

  // Pulses start and follows the run until done (bounded); cycles counts the
  // start cycle through the done cycle inclusive.
  task automatic run(input int n, input int poke_at, output int cycles,
                     output int toggles, output int dones, output bit hung,
                     output logic busy_after);
    logic last_s;
    bit fin;
    @(negedge clk);
    start = 1'b1;
    n_meas = n[7:0];
    last_s = stim;
    cycles = 1;
    toggles = 0;
    dones = 0;
    fin = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      @(negedge clk);
      start = (k + 1 == poke_at);
      n_meas = 8'd200;
      cycles++;
      if (stim !== last_s) toggles++;
      last_s = stim;
      if (done === 1'b1) begin
        dones++;
        fin = 1'b1;
      end
    end
    start = 1'b0;
    hung = !fin;
    @(negedge clk);
    if (done === 1'b1) dones++;
    busy_after = busy;
  endtask

  task automatic test_reset();
    vectors++;
    if ({stim, busy, done, timeout_err, precheck_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got %b want 00000", {stim, busy, done, timeout_err, precheck_err});
    end
    vectors++;
    if (meas_count !== 8'd0 || last_delay !== '0 || max_delay !== '0) begin
      miscompares++;
      $display("FAIL reset_results: got meas=%0d last=%0d max=%0d want 0 0 0", meas_count, last_delay, max_delay);
    end
    vectors++;
    if (min_delay !== ALL_ONES) begin
      miscompares++;
      $display("FAIL reset_min: got %h want %h", min_delay, ALL_ONES);
    end
    $display("test_reset: checked reset state");
  endtask

  task automatic test_line(input string name, input int n, input int d[$], input int poke_at);
    int exp_min, exp_max, exp_cyc, dl;
    int cycles, toggles, dones;
    bit hung;
    logic busy_after;
    exp_min = 2**CNT_W - 1;
    exp_max = 0;
    exp_cyc = 2;
    for (int i = 0; i < n; i++) begin
      dl = d[i] + ZERO_DELAY_OFFSET;
      if (dl < exp_min) exp_min = dl;
      if (dl > exp_max) exp_max = dl;
      exp_last = dl;
      exp_cyc += 1 + dl + SETTLE;
    end
    if (n % 2 == 1) exp_stim = ~exp_stim;
    dq.delete();
    for (int i = 0; i < n; i++) dq.push_back(d[i]);
    run(n, poke_at, cycles, toggles, dones, hung, busy_after);
    vectors++;
    if (hung) begin
      miscompares++;
      $display("FAIL %s no_done: done not seen within cycle budget", name);
    end
    vectors++;
    if (cycles != exp_cyc) begin
      miscompares++;
      $display("FAIL %s run_length: got %0d want %0d", name, cycles, exp_cyc);
    end
    vectors++;
    if (toggles != n || dones != 1) begin
      miscompares++;
      $display("FAIL %s toggles/dones: got %0d/%0d want %0d/1", name, toggles, dones, n);
    end
    vectors++;
    if (last_delay !== CNT_W'(exp_last) || min_delay !== CNT_W'(exp_min) || max_delay !== CNT_W'(exp_max)) begin
      miscompares++;
      $display("FAIL %s delays: got last=%0d min=%0d max=%0d want %0d %0d %0d",
               name, last_delay, min_delay, max_delay, exp_last, exp_min, exp_max);
    end
    vectors++;
    if (meas_count !== n[7:0] || timeout_err !== 1'b0 || precheck_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s status: got meas=%0d tmo=%b pre=%b want %0d 0 0", name, meas_count, timeout_err, precheck_err, n);
    end
    vectors++;
    if (stim !== exp_stim || busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL %s stim/busy: got %b/%b want %b/0", name, stim, busy_after, exp_stim);
    end
    $display("test_line %s: n=%0d last=%0d min=%0d max=%0d cycles=%0d", name, n, last_delay, min_delay, max_delay, cycles);
  endtask

  task automatic test_random();
    int d[$];
    int n;
    for (int r = 0; r < 6; r++) begin
      d.delete();
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) d.push_back($urandom_range(0, TIMEOUT - ZERO_DELAY_OFFSET - 1));
      test_line($sformatf("random%0d", r), n, d, 0);
    end
  endtask

  task automatic test_timeout();
    int cycles, toggles, dones;
    bit hung;
    logic busy_after;
    if (exp_stim == 1'b0) test_line("timeout_prep", 1, '{0}, 0);
    tied_val = 1'b0;
    tied = 1'b1;
    repeat (4) @(negedge clk);
    run(5, 0, cycles, toggles, dones, hung, busy_after);
    exp_stim = 1'b0;
    vectors++;
    if (hung || dones != 1 || cycles != TIMEOUT + 3) begin
      miscompares++;
      $display("FAIL timeout_run: got hung=%0d dones=%0d cycles=%0d want 0 1 %0d", hung, dones, cycles, TIMEOUT + 3);
    end
    vectors++;
    if (timeout_err !== 1'b1 || precheck_err !== 1'b0 || meas_count !== 8'd0) begin
      miscompares++;
      $display("FAIL timeout_flags: got tmo=%b pre=%b meas=%0d want 1 0 0", timeout_err, precheck_err, meas_count);
    end
    vectors++;
    if (min_delay !== ALL_ONES || max_delay !== '0 || last_delay !== CNT_W'(exp_last) || stim !== exp_stim) begin
      miscompares++;
      $display("FAIL timeout_results: got min=%h max=%0d last=%0d stim=%b want %h 0 %0d %b",
               min_delay, max_delay, last_delay, stim, ALL_ONES, exp_last, exp_stim);
    end
    $display("test_timeout: tmo=%b cycles=%0d", timeout_err, cycles);
  endtask

  task automatic test_precheck();
    int cycles, toggles, dones;
    bit hung;
    logic busy_after;
    // resp held equal to stim (not inverted) fails the pre-check.
    run(3, 0, cycles, toggles, dones, hung, busy_after);
    vectors++;
    if (precheck_err !== 1'b1 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL precheck_flags: got pre=%b tmo=%b want 1 0", precheck_err, timeout_err);
    end
    vectors++;
    if (hung || cycles != 2 || toggles != 0 || dones != 1 || stim !== exp_stim || meas_count !== 8'd0) begin
      miscompares++;
      $display("FAIL precheck_run: got cycles=%0d toggles=%0d dones=%0d stim=%b meas=%0d want 2 0 1 %b 0",
               cycles, toggles, dones, stim, meas_count, exp_stim);
    end
    $display("test_precheck: pre=%b cycles=%0d", precheck_err, cycles);
    run(0, 0, cycles, toggles, dones, hung, busy_after);
    vectors++;
    if (precheck_err !== 1'b0 || hung || cycles != 2 || toggles != 0 || dones != 1 || meas_count !== 8'd0) begin
      miscompares++;
      $display("FAIL zero_meas: got pre=%b cycles=%0d toggles=%0d dones=%0d meas=%0d want 0 2 0 1 0",
               precheck_err, cycles, toggles, dones, meas_count);
    end
    vectors++;
    if (last_delay !== CNT_W'(exp_last) || min_delay !== ALL_ONES || busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_meas_results: got last=%0d min=%h busy=%b want %0d %h 0", last_delay, min_delay, busy_after, exp_last, ALL_ONES);
    end
    $display("test_zero_meas: cycles=%0d meas=%0d", cycles, meas_count);
    tied = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dq.delete();
    dq.push_back(12);
    @(negedge clk);
    start = 1'b1;
    n_meas = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    vectors++;
    if (stim !== ~exp_stim || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midrun_before_reset: got stim=%b busy=%b want %b 1", stim, busy, ~exp_stim);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (stim !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || min_delay !== ALL_ONES || max_delay !== '0) begin
      miscompares++;
      $display("FAIL midrun_reset: got stim=%b busy=%b done=%b min=%h max=%0d want 0 0 0 %h 0",
               stim, busy, done, min_delay, max_delay, ALL_ONES);
    end
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrun_no_done: got dones=%0d busy=%b want 0 0", dones, busy);
    end
    exp_stim = 1'b0;
    exp_last = 0;
    $display("test_reset_mid_run: stim=%b busy=%b dones=%0d", stim, busy, dones);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_line("zero_delay", 4, '{0, 0, 0, 0}, 0);
    test_line("line10", 2, '{10, 10}, 0);
    test_line("alt5_9", 3, '{5, 9, 5}, 0);
    test_random();
    test_timeout();
    test_precheck();
    test_reset_mid_run();
    test_line("busy_start", 2, '{2, 7}, 5);
    test_line("back_to_back", 1, '{16}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
